sync_pkt_fifo: RTL and testbench

- Parametrised single-clock frame FIFO: a dual-port RAM array wrapped with write/commit/discard pointer logic and a show-ahead ready/valid read port.
- Used in switch port buffering. A frame is written word by word, then committed (made visible to the reader) or discarded (write pointer rolled back) once the MAC knows the FCS result.
- Generalises the plain registered dual-port RAM with frame atomicity, flow control, occupancy tracking and selectable RAM output latency.

---
 rtl/sync_pkt_fifo.sv | 163 ++++++++++++++++
 tb/tb_sync_pkt_fifo.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_pkt_fifo.sv
// Single-clock frame FIFO: words are written, then committed or discarded as a frame;
// committed words stream out through a show-ahead ready/valid port backed by a skid buffer.
module sync_pkt_fifo #(
   parameter int unsigned  pDATA_W      = 8,
   parameter int unsigned  pWORDS       = 1024,
   parameter int unsigned  pUSE_OUT_REG = 1,
   parameter int unsigned  pUSE_EAB     = 1,
   localparam int unsigned cADDR_W      = $clog2(pWORDS)
) (
   input  logic               iclk,
   input  logic               irst,
   input  logic [pDATA_W-1:0] idata,
   input  logic               iwr_ena,
   input  logic               icommit,
   input  logic               idiscard,
   output logic [pDATA_W-1:0] odata,
   output logic               oval,
   input  logic               irdy,
   output logic               ofull,
   output logic               oempty,
   output logic [cADDR_W:0]   ousedw,
   output logic               odrop
);

   localparam int unsigned PTR_W  = cADDR_W + 1;
   localparam int unsigned LAT    = (pUSE_OUT_REG != 0) ? 2 : 1;
   localparam int unsigned SKID_D = LAT + 1;
   localparam int unsigned CNT_W  = $clog2(SKID_D + 1);

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   cm_ptr_q, cm_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   usedw_q, usedw_d;
   logic               err_q, err_d;
   logic               drop_q, drop_d;
   logic               full_q, full_d;
   logic               empty_q, empty_d;
   logic               oval_q, oval_d;
   logic [LAT-1:0]     vld_q, vld_d;
   logic [CNT_W-1:0]   skid_cnt_q, skid_cnt_d;
   logic [pDATA_W-1:0] skid_q [SKID_D];
   logic [pDATA_W-1:0] skid_d [SKID_D];

   logic               wr_en, ovf, discard, commit;
   logic [PTR_W-1:0]   wr_inc;
   logic               pop, issue, arrive;
   logic [CNT_W-1:0]   inflight, occ, cnt_after_pop;
   logic [pDATA_W-1:0] ram_rd_q;
   logic [pDATA_W-1:0] ram_dout;

   // Write side: an overflowing frame is poisoned, and a commit of a poisoned frame drops it.
   always_comb begin
      wr_en    = iwr_ena & ~full_q;
      ovf      = iwr_ena & full_q;
      discard  = idiscard | (icommit & (err_q | ovf));
      commit   = icommit & ~discard;
      wr_inc   = wr_en ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      wr_ptr_d = discard ? cm_ptr_q : wr_inc;
      cm_ptr_d = commit ? wr_inc : cm_ptr_q;
      err_d    = (icommit | idiscard) ? 1'b0 : (err_q | ovf);
      drop_d   = discard;
   end

   // Read side: keep skid occupancy plus in-flight reads within the skid depth.
   always_comb begin
      pop      = oval_q & irdy;
      inflight = '0;
      for (int i = 0; i < int'(LAT); i++) begin
         inflight = inflight + CNT_W'(vld_q[i]);
      end
      cnt_after_pop = skid_cnt_q - CNT_W'(pop);
      occ           = cnt_after_pop + inflight;
      issue         = (cm_ptr_q != rd_ptr_q) && (occ < CNT_W'(SKID_D));
      rd_ptr_d      = issue ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      vld_d         = (vld_q << 1) | LAT'(issue);
      arrive        = vld_q[LAT-1];

      skid_d = skid_q;
      if (pop) begin
         for (int i = 0; i < int'(SKID_D) - 1; i++) begin
            skid_d[i] = skid_q[i+1];
         end
      end
      if (arrive) begin
         for (int i = 0; i < int'(SKID_D); i++) begin
            if (CNT_W'(i) == cnt_after_pop) begin
               skid_d[i] = ram_dout;
            end
         end
      end
      skid_cnt_d = cnt_after_pop + CNT_W'(arrive);
      oval_d     = (skid_cnt_d != '0);

      usedw_d = cm_ptr_q - rd_ptr_q;
      empty_d = (cm_ptr_d == rd_ptr_d) && (vld_d == '0) && (skid_cnt_d == '0);
      full_d  = ((wr_ptr_d - rd_ptr_d) == PTR_W'(pWORDS));
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         wr_ptr_q   <= '0;
         cm_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         usedw_q    <= '0;
         err_q      <= 1'b0;
         drop_q     <= 1'b0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         oval_q     <= 1'b0;
         vld_q      <= '0;
         skid_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         cm_ptr_q   <= cm_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         usedw_q    <= usedw_d;
         err_q      <= err_d;
         drop_q     <= drop_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         oval_q     <= oval_d;
         vld_q      <= vld_d;
         skid_cnt_q <= skid_cnt_d;
      end
   end

   always_ff @(posedge iclk) begin
      skid_q <= skid_d;
   end

   // Storage array; both variants behave identically, only the mapping hint differs.
   if (pUSE_EAB != 0) begin : g_eab
      (* ram_style = "block" *) logic [pDATA_W-1:0] mem [pWORDS];
      always_ff @(posedge iclk) begin
         if (wr_en) mem[wr_ptr_q[cADDR_W-1:0]] <= idata;
         if (issue) ram_rd_q <= mem[rd_ptr_q[cADDR_W-1:0]];
      end
   end else begin : g_lcell
      (* ram_style = "distributed" *) logic [pDATA_W-1:0] mem [pWORDS];
      always_ff @(posedge iclk) begin
         if (wr_en) mem[wr_ptr_q[cADDR_W-1:0]] <= idata;
         if (issue) ram_rd_q <= mem[rd_ptr_q[cADDR_W-1:0]];
      end
   end

   if (LAT == 2) begin : g_oreg
      logic [pDATA_W-1:0] ram_out_q;
      always_ff @(posedge iclk) begin
         if (vld_q[0]) ram_out_q <= ram_rd_q;
      end
      assign ram_dout = ram_out_q;
   end else begin : g_noreg
      assign ram_dout = ram_rd_q;
   end

   assign odata  = skid_q[0];
   assign oval   = oval_q;
   assign ofull  = full_q;
   assign oempty = empty_q;
   assign ousedw = usedw_q;
   assign odrop  = drop_q;

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Directed bench for sync_pkt_fifo: one L=2 and one L=1 instance share the same stimulus.
module tb_sync_pkt_fifo;

   logic       iclk     = 1'b0;
   logic       irst     = 1'b1;
   logic [7:0] idata    = '0;
   logic       iwr_ena  = 1'b0;
   logic       icommit  = 1'b0;
   logic       idiscard = 1'b0;
   logic       irdy     = 1'b0;

   logic [7:0] o2_data, o1_data;
   logic       o2_val, o1_val, o2_full, o1_full, o2_empty, o1_empty, o2_drop, o1_drop;
   logic [4:0] o2_usedw, o1_usedw;

   int         errors  = 0;
   int         checks  = 0;
   logic [7:0] exp_mem [256];
   int         exp_cnt = 0;
   int         m2_idx  = 0;
   int         m1_idx  = 0;
   bit         rand_rdy = 1'b0;

   sync_pkt_fifo #(.pDATA_W(8), .pWORDS(16), .pUSE_OUT_REG(1), .pUSE_EAB(1)) u_dut2 (
      .iclk(iclk), .irst(irst), .idata(idata), .iwr_ena(iwr_ena), .icommit(icommit),
      .idiscard(idiscard), .odata(o2_data), .oval(o2_val), .irdy(irdy), .ofull(o2_full),
      .oempty(o2_empty), .ousedw(o2_usedw), .odrop(o2_drop));

   sync_pkt_fifo #(.pDATA_W(8), .pWORDS(16), .pUSE_OUT_REG(0), .pUSE_EAB(0)) u_dut1 (
      .iclk(iclk), .irst(irst), .idata(idata), .iwr_ena(iwr_ena), .icommit(icommit),
      .idiscard(idiscard), .odata(o1_data), .oval(o1_val), .irdy(irdy), .ofull(o1_full),
      .oempty(o1_empty), .ousedw(o1_usedw), .odrop(o1_drop));

   always #5 iclk = ~iclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge iclk);
      #1;
      if (rand_rdy) irdy = 1'($urandom_range(0, 1));
   endtask

   task automatic wr(input logic [7:0] d, input logic cm);
      idata   = d;
      iwr_ena = 1'b1;
      icommit = cm;
      tick();
      iwr_ena = 1'b0;
      icommit = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      exp_mem[exp_cnt] = d;
      exp_cnt++;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_val2"},   32'(o2_val),   0);
      chk({tag, "_val1"},   32'(o1_val),   0);
      chk({tag, "_empty2"}, 32'(o2_empty), 1);
      chk({tag, "_empty1"}, 32'(o1_empty), 1);
      chk({tag, "_used2"},  32'(o2_usedw), 0);
      chk({tag, "_used1"},  32'(o1_usedw), 0);
      chk({tag, "_full2"},  32'(o2_full),  0);
      chk({tag, "_full1"},  32'(o1_full),  0);
   endtask

   task automatic wait_empty(input string tag);
      int n = 0;
      while (!(o2_empty && o1_empty) && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 32'(n < 200), 1);
   endtask

   task automatic wait_used0();
      int n = 0;
      while ((o2_usedw != 0 || o1_usedw != 0) && n < 200) begin
         tick();
         n++;
      end
      chk("used0_timeout", 32'(n < 200), 1);
   endtask

   // Head of each instance must always be the next expected committed word.
   always @(negedge iclk) begin
      if (irst) m2_idx = 0;
      else if (o2_val) begin
         chk("dut2_overrun", 32'(m2_idx < exp_cnt), 1);
         chk("dut2_data", 32'(o2_data), 32'(exp_mem[m2_idx]));
         if (irdy) m2_idx++;
      end
   end

   always @(negedge iclk) begin
      if (irst) m1_idx = 0;
      else if (o1_val) begin
         chk("dut1_overrun", 32'(m1_idx < exp_cnt), 1);
         chk("dut1_data", 32'(o1_data), 32'(exp_mem[m1_idx]));
         if (irdy) m1_idx++;
      end
   end

   initial begin
      // reset state
      irst = 1'b1;
      tick();
      tick();
      chk_idle("rst");
      chk("rst_drop2", 32'(o2_drop), 0);
      chk("rst_drop1", 32'(o1_drop), 0);
      irst = 1'b0;

      // single frame, commit with last word, latency and streaming
      irdy = 1'b1;
      push(8'h11); wr(8'h11, 1'b0);
      push(8'h12); wr(8'h12, 1'b0);
      push(8'h13); wr(8'h13, 1'b0);
      chk("t1_precommit_empty", 32'(o2_empty), 1);
      chk("t1_precommit_used",  32'(o2_usedw), 0);
      push(8'h14); wr(8'h14, 1'b1);
      chk("t1_e0_val2",   32'(o2_val),   0);
      chk("t1_e0_empty2", 32'(o2_empty), 0);
      tick();
      chk("t1_e1_val2", 32'(o2_val), 0);
      chk("t1_e1_val1", 32'(o1_val), 0);
      tick();
      chk("t1_e2_val2",  32'(o2_val),  0);
      chk("t1_e2_val1",  32'(o1_val),  1);
      chk("t1_e2_data1", 32'(o1_data), 32'h11);
      tick();
      chk("t1_e3_val2",  32'(o2_val),  1);
      chk("t1_e3_data2", 32'(o2_data), 32'h11);
      chk("t1_e3_data1", 32'(o1_data), 32'h12);
      tick();
      chk("t1_e4_data2", 32'(o2_data), 32'h12);
      tick();
      chk("t1_e5_data2", 32'(o2_data), 32'h13);
      tick();
      chk("t1_e6_data2", 32'(o2_data), 32'h14);
      tick();
      chk_idle("t1_end");

      // discarded frame followed by a committed one
      wr(8'h31, 1'b0);
      wr(8'h32, 1'b0);
      wr(8'h33, 1'b0);
      idiscard = 1'b1;
      tick();
      idiscard = 1'b0;
      chk("t2_drop2", 32'(o2_drop), 1);
      chk("t2_drop1", 32'(o1_drop), 1);
      tick();
      chk("t2_drop2_off", 32'(o2_drop), 0);
      chk("t2_drop1_off", 32'(o1_drop), 0);
      chk("t2_noval2",    32'(o2_val),  0);
      push(8'hA1); wr(8'hA1, 1'b0);
      push(8'hA2); wr(8'hA2, 1'b1);
      tick();
      chk("t2_used2_peak", 32'(o2_usedw), 2);
      chk("t2_used1_peak", 32'(o1_usedw), 2);
      tick();
      chk("t2_used2_next", 32'(o2_usedw), 1);
      chk("t2_used1_next", 32'(o1_usedw), 1);
      tick(); tick(); tick(); tick();
      chk_idle("t2_end");

      // overflow poisons the frame; commit becomes a discard
      irdy = 1'b0;
      for (int i = 0; i < 15; i++) wr(8'(8'h40 + i), 1'b0);
      chk("t3_notfull2", 32'(o2_full), 0);
      chk("t3_notfull1", 32'(o1_full), 0);
      wr(8'h4F, 1'b0);
      chk("t3_full2", 32'(o2_full), 1);
      chk("t3_full1", 32'(o1_full), 1);
      wr(8'h50, 1'b0);
      chk("t3_still_full2", 32'(o2_full), 1);
      icommit = 1'b1;
      tick();
      icommit = 1'b0;
      chk("t3_drop2",  32'(o2_drop),  1);
      chk("t3_drop1",  32'(o1_drop),  1);
      chk("t3_empty2", 32'(o2_empty), 1);
      chk("t3_full2_clr", 32'(o2_full), 0);
      tick();
      chk("t3_drop2_off", 32'(o2_drop), 0);
      chk_idle("t3_end");

      // commit and discard together with a same-cycle write
      irdy     = 1'b1;
      idata    = 8'h77;
      iwr_ena  = 1'b1;
      icommit  = 1'b1;
      idiscard = 1'b1;
      tick();
      iwr_ena  = 1'b0;
      icommit  = 1'b0;
      idiscard = 1'b0;
      chk("t5_drop2", 32'(o2_drop), 1);
      chk("t5_drop1", 32'(o1_drop), 1);
      tick(); tick(); tick();
      chk_idle("t5_end");

      // streaming frames across pointer wrap with random back-pressure
      rand_rdy = 1'b1;
      for (int f = 0; f < 8; f++) begin
         wait_used0();
         for (int w = 0; w < 5; w++) begin
            push(8'(8'h80 + f * 16 + w));
            wr(8'(8'h80 + f * 16 + w), 1'(w == 4));
         end
      end
      rand_rdy = 1'b0;
      irdy     = 1'b1;
      wait_empty("t4_drain");
      chk("t4_count2", 32'(m2_idx), 32'(exp_cnt));
      chk("t4_count1", 32'(m1_idx), 32'(exp_cnt));
      chk("t4_total",  32'(exp_cnt), 46);

      // reset with a loaded skid buffer and a partial frame pending
      irdy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         push(8'(8'h61 + i));
         wr(8'(8'h61 + i), 1'(i == 5));
      end
      for (int i = 0; i < 8; i++) tick();
      chk("t6_val2",   32'(o2_val),   1);
      chk("t6_data2",  32'(o2_data),  32'h61);
      chk("t6_used2",  32'(o2_usedw), 3);
      chk("t6_data1",  32'(o1_data),  32'h61);
      chk("t6_used1",  32'(o1_usedw), 4);
      wr(8'h6A, 1'b0);
      wr(8'h6B, 1'b0);
      idata   = 8'h6C;
      iwr_ena = 1'b1;
      irst    = 1'b1;
      exp_cnt = 0;
      tick();
      iwr_ena = 1'b0;
      irst    = 1'b0;
      chk_idle("t6_rst");
      chk("t6_rst_drop2", 32'(o2_drop), 0);
      irdy = 1'b1;
      push(8'hB1); wr(8'hB1, 1'b0);
      push(8'hB2); wr(8'hB2, 1'b0);
      push(8'hB3); wr(8'hB3, 1'b1);
      tick();
      wait_empty("t6_drain");
      chk("t6_count2", 32'(m2_idx), 3);
      chk("t6_count1", 32'(m1_idx), 3);
      tick();
      chk_idle("t6_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
